// File: rtl/annulling_reducer.sv
// Masks annulled channels, reduces the survivors with a fixed bitwise operator and
// carries the result through an elastic valid/ready pipeline with a conflict tally.
module annulling_reducer #(
  parameter int    WORD_WIDTH     = 8,
  parameter int    INPUT_COUNT    = 4,
  parameter int    PIPELINE_DEPTH = 2,
  parameter string REDUCE_OP      = "OR",
  parameter int    COUNT_WIDTH    = 8
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_WIDTH*INPUT_COUNT-1:0] words_in,
  input  logic [INPUT_COUNT-1:0]            annul_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_WIDTH-1:0]             word_out,
  output logic                              conflict_out,
  output logic                              none_out,
  output logic [COUNT_WIDTH-1:0]            conflict_count
);

  localparam logic [1:0] OP_OR  = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_SEL = (REDUCE_OP == "AND") ? OP_AND :
                                  (REDUCE_OP == "XOR") ? OP_XOR : OP_OR;
  localparam int SW   = $clog2(INPUT_COUNT + 1);
  localparam int LAST = PIPELINE_DEPTH - 1;

  logic [WORD_WIDTH-1:0] w_acc;
  logic [WORD_WIDTH-1:0] w_word;
  logic [SW-1:0]         w_alive;
  logic                  w_conflict;
  logic                  w_none;
  logic [LAST:0]         w_load;
  logic                  w_any_free;

  // Declaration values give the same power-up state as a clear.
  logic [LAST:0]                 r_valid    = {PIPELINE_DEPTH{1'b0}};
  logic [LAST:0][WORD_WIDTH-1:0] r_word     = {(PIPELINE_DEPTH*WORD_WIDTH){1'b0}};
  logic [LAST:0]                 r_conflict = {PIPELINE_DEPTH{1'b0}};
  logic [LAST:0]                 r_none     = {PIPELINE_DEPTH{1'b0}};
  logic [COUNT_WIDTH-1:0]        r_count    = {COUNT_WIDTH{1'b0}};

  // Reduce surviving channels; annulled ones contribute the operator identity.
  always_comb begin
    w_acc   = (OP_SEL == OP_AND) ? {WORD_WIDTH{1'b1}} : {WORD_WIDTH{1'b0}};
    w_alive = {SW{1'b0}};
    for (int i = 0; i < INPUT_COUNT; i++) begin
      if (!annul_in[i]) begin
        w_alive = w_alive + SW'(1);
        case (OP_SEL)
          OP_AND:  w_acc = w_acc & words_in[i*WORD_WIDTH +: WORD_WIDTH];
          OP_XOR:  w_acc = w_acc ^ words_in[i*WORD_WIDTH +: WORD_WIDTH];
          default: w_acc = w_acc | words_in[i*WORD_WIDTH +: WORD_WIDTH];
        endcase
      end else begin
        w_acc = w_acc;
      end
    end
    w_none     = (w_alive == {SW{1'b0}});
    w_conflict = (w_alive > SW'(1));
    if (w_none) begin
      w_word = {WORD_WIDTH{1'b0}};
    end else begin
      w_word = w_acc;
    end
  end

  // A stage may load if it or any stage downstream is empty, or the output drains.
  always_comb begin
    w_load = {PIPELINE_DEPTH{1'b0}};
    for (int s = 0; s < PIPELINE_DEPTH; s++) begin
      w_any_free = out_ready;
      for (int t = s; t < PIPELINE_DEPTH; t++) begin
        if (!r_valid[t]) begin
          w_any_free = 1'b1;
        end else begin
          w_any_free = w_any_free;
        end
      end
      w_load[s] = w_any_free;
    end
  end

  // Pipeline stages and saturating conflict counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_valid    <= {PIPELINE_DEPTH{1'b0}};
      r_word     <= {(PIPELINE_DEPTH*WORD_WIDTH){1'b0}};
      r_conflict <= {PIPELINE_DEPTH{1'b0}};
      r_none     <= {PIPELINE_DEPTH{1'b0}};
      r_count    <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (w_load[0]) begin
        r_valid[0]    <= in_valid;
        r_word[0]     <= w_word;
        r_conflict[0] <= w_conflict;
        r_none[0]     <= w_none;
      end
      for (int s = 1; s < PIPELINE_DEPTH; s++) begin
        if (w_load[s]) begin
          r_valid[s]    <= r_valid[s-1];
          r_word[s]     <= r_word[s-1];
          r_conflict[s] <= r_conflict[s-1];
          r_none[s]     <= r_none[s-1];
        end
      end
      if (r_valid[LAST] && out_ready && r_conflict[LAST] &&
          (r_count != {COUNT_WIDTH{1'b1}})) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign in_ready       = w_load[0];
  assign out_valid      = r_valid[LAST];
  assign word_out       = r_word[LAST];
  assign conflict_out   = r_conflict[LAST];
  assign none_out       = r_none[LAST];
  assign conflict_count = r_count;

endmodule

// File: tb/tb_annulling_reducer.sv
// Drives three reducer variants (OR/depth2, AND/depth3/2-bit count, XOR/depth1)
// and checks them against a queue-based model of the handshake and reduction rules.
module tb_annulling_reducer;
  localparam int N = 3;

  typedef struct {
    logic [7:0] w;
    logic       c;
    logic       n;
    int         t;
  } exp_t;

  logic        clock     = 1'b0;
  logic        clear     = 1'b1;
  logic        out_ready = 1'b1;
  logic        iv [N];
  logic [31:0] wi [N];
  logic [3:0]  an [N];
  logic        ir [N];
  logic        ov [N];
  logic        co [N];
  logic        no [N];
  logic [7:0]  wo [N];
  logic [7:0]  cnt_or, cnt_xor;
  logic [1:0]  cnt_and;
  logic [7:0]  cnt [N];

  int   depth_c [N] = '{2, 3, 1};
  int   op_c    [N] = '{0, 1, 2};
  int   cmax_c  [N] = '{255, 3, 255};
  exp_t q       [N][$];
  int   mcnt    [N] = '{0, 0, 0};
  int   n_out   [N] = '{0, 0, 0};
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  assign cnt[0] = cnt_or;
  assign cnt[1] = {6'b000000, cnt_and};
  assign cnt[2] = cnt_xor;

  annulling_reducer #(.WORD_WIDTH(8), .INPUT_COUNT(4), .PIPELINE_DEPTH(2),
                      .REDUCE_OP("OR"), .COUNT_WIDTH(8)) u_or (
    .clock(clock), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
    .words_in(wi[0]), .annul_in(an[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .word_out(wo[0]), .conflict_out(co[0]), .none_out(no[0]), .conflict_count(cnt_or));

  annulling_reducer #(.WORD_WIDTH(8), .INPUT_COUNT(4), .PIPELINE_DEPTH(3),
                      .REDUCE_OP("AND"), .COUNT_WIDTH(2)) u_and (
    .clock(clock), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
    .words_in(wi[1]), .annul_in(an[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .word_out(wo[1]), .conflict_out(co[1]), .none_out(no[1]), .conflict_count(cnt_and));

  annulling_reducer #(.WORD_WIDTH(8), .INPUT_COUNT(4), .PIPELINE_DEPTH(1),
                      .REDUCE_OP("XOR"), .COUNT_WIDTH(8)) u_xor (
    .clock(clock), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]),
    .words_in(wi[2]), .annul_in(an[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .word_out(wo[2]), .conflict_out(co[2]), .none_out(no[2]), .conflict_count(cnt_xor));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int op, input logic [31:0] w,
                                 input logic [3:0] a, input int t);
    exp_t       e;
    int         alive;
    logic [7:0] acc, ident, ch;
    ident = (op == 1) ? 8'hFF : 8'h00;
    acc   = ident;
    alive = 0;
    for (int i = 0; i < 4; i++) begin
      ch = a[i] ? ident : w[i*8 +: 8];
      if (!a[i]) alive++;
      case (op)
        1:       acc = acc & ch;
        2:       acc = acc ^ ch;
        default: acc = acc | ch;
      endcase
    end
    e.n = (alive == 0);
    e.c = (alive >= 2);
    e.w = e.n ? 8'h00 : acc;
    e.t = t;
    return e;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Model and compare: a result is due once its head entry has aged depth-1 edges.
  always @(negedge clock) begin
    for (int k = 0; k < N; k++) begin
      logic exp_vld;
      exp_t h;
      exp_vld = (q[k].size() > 0) && (cyc >= q[k][0].t + depth_c[k] - 1);
      chk($sformatf("out_valid[%0d] cyc %0d", k, cyc), int'(ov[k]), int'(exp_vld));
      chk($sformatf("in_ready[%0d] cyc %0d", k, cyc), int'(ir[k]),
          int'((q[k].size() < depth_c[k]) || out_ready));
      chk($sformatf("conflict_count[%0d] cyc %0d", k, cyc), int'(cnt[k]), mcnt[k]);
      if (exp_vld && ov[k]) begin
        h = q[k][0];
        chk($sformatf("word_out[%0d] cyc %0d", k, cyc), int'(wo[k]), int'(h.w));
        chk($sformatf("conflict_out[%0d] cyc %0d", k, cyc), int'(co[k]), int'(h.c));
        chk($sformatf("none_out[%0d] cyc %0d", k, cyc), int'(no[k]), int'(h.n));
      end
      if (clear) begin
        q[k].delete();
        mcnt[k] = 0;
      end else begin
        if (ov[k] && out_ready && (q[k].size() > 0)) begin
          h = q[k].pop_front();
          n_out[k]++;
          if (h.c && (mcnt[k] < cmax_c[k])) mcnt[k]++;
        end
        if (iv[k] && ir[k]) q[k].push_back(model(op_c[k], wi[k], an[k], cyc + 1));
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_one(input logic [31:0] w, input logic [3:0] a);
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b1;
      wi[k] = w;
      an[k] = a;
    end
    cycle();
    for (int k = 0; k < N; k++) iv[k] = 1'b0;
  endtask

  logic [31:0] bp_w [6] = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
                            32'hDDEEFF00, 32'h0F1E2D3C, 32'h4B5A6978};
  logic [3:0]  bp_a [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0101};
  int          ptr  [N];
  logic        acc_now [N];
  logic        saw_low_or;

  initial begin
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0;
      wi[k] = 32'h00000000;
      an[k] = 4'b0000;
    end
    clear = 1'b1;
    idle(2);
    clear = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset out_valid[%0d]", k), int'(ov[k]), 0);
      chk($sformatf("reset in_ready[%0d]", k), int'(ir[k]), 1);
      chk($sformatf("reset count[%0d]", k), int'(cnt[k]), 0);
    end

    // OR: channels 0 and 2 survive -> 0x01|0x04, two cycles of latency.
    send_one(32'h08040201, 4'b1010);
    chk("or_latency_early", int'(ov[0]), 0);
    chk("xor_latency_1", int'(ov[2]), 1);
    cycle();
    chk("or_valid", int'(ov[0]), 1);
    chk("or_word", int'(wo[0]), 32'h05);
    chk("or_conflict", int'(co[0]), 1);
    chk("or_none", int'(no[0]), 0);
    cycle();
    chk("or_count", int'(cnt[0]), 1);
    idle(3);

    // AND: words ch0..ch3 = F0,3C,FF,00.
    send_one(32'h00FF3CF0, 4'b1000);
    send_one(32'h00FF3CF0, 4'b1001);
    send_one(32'h00FF3CF0, 4'b1111);
    chk("and_w1", int'(wo[1]), 32'h30);
    chk("and_c1", int'(co[1]), 1);
    cycle();
    chk("and_w2", int'(wo[1]), 32'h3C);
    cycle();
    chk("and_w3", int'(wo[1]), 32'h00);
    chk("and_none3", int'(no[1]), 1);
    chk("and_c3", int'(co[1]), 0);
    idle(4);

    // XOR: only channel 0 survives.
    send_one(32'h5A3C0FA5, 4'b1110);
    chk("xor_word", int'(wo[2]), 32'hA5);
    chk("xor_conflict", int'(co[2]), 0);
    cycle();
    chk("xor_count_unchanged", int'(cnt[2]), 3);
    idle(4);

    // Back-to-back inputs with out_ready low on loop cycles 3..7.
    saw_low_or = 1'b0;
    for (int k = 0; k < N; k++) begin
      ptr[k]   = 0;
      n_out[k] = 0;
    end
    for (int c = 0; c < 24; c++) begin
      out_ready = !((c >= 3) && (c <= 7));
      for (int k = 0; k < N; k++) begin
        iv[k] = (ptr[k] < 6);
        wi[k] = bp_w[(ptr[k] < 6) ? ptr[k] : 0];
        an[k] = bp_a[(ptr[k] < 6) ? ptr[k] : 0];
      end
      #1;
      if (!ir[0]) saw_low_or = 1'b1;
      for (int k = 0; k < N; k++) acc_now[k] = iv[k] && ir[k];
      @(posedge clock);
      #1;
      for (int k = 0; k < N; k++) if (acc_now[k]) ptr[k]++;
    end
    for (int k = 0; k < N; k++) iv[k] = 1'b0;
    out_ready = 1'b1;
    chk("bp_or_in_ready_fell", int'(saw_low_or), 1);
    for (int k = 0; k < N; k++) chk($sformatf("bp_outputs[%0d]", k), n_out[k], 6);

    // Saturation with a 2-bit counter on the AND variant.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) send_one(32'hA5C3F00F + i, 4'b0000);
    idle(5);
    chk("sat_and_count", int'(cnt[1]), 3);
    chk("sat_or_count", int'(cnt[0]), 5);
    chk("sat_xor_count", int'(cnt[2]), 5);

    // Clear with results in flight.
    send_one(32'h12345678, 4'b0011);
    send_one(32'h9ABCDEF0, 4'b0011);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("clr out_valid[%0d]", k), int'(ov[k]), 0);
      chk($sformatf("clr count[%0d]", k), int'(cnt[k]), 0);
      chk($sformatf("clr in_ready[%0d]", k), int'(ir[k]), 1);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
